// File: rtl/kyber_enc_pkg.sv
// Shared definitions for the kyber_pke_enc host-side feeder: operand type codes,
// operand lengths and the feeder FSM state encoding.
package kyber_enc_pkg;

    localparam int IDX_W = 16;

    localparam logic [3:0] T_NONE = 4'd0;
    localparam logic [3:0] T_R    = 4'd1;
    localparam logic [3:0] T_EKT  = 4'd2;
    localparam logic [3:0] T_MSG  = 4'd3;
    localparam logic [3:0] T_SEED = 4'd4;

    localparam int LEN_R    = 32;
    localparam int LEN_MSG  = 32;
    localparam int LEN_SEED = 32;

    function automatic int LEN_EKT(input int k);
        return 384 * k;
    endfunction

    function automatic logic isLegalType(input logic [3:0] t);
        return (t >= T_R) && (t <= T_SEED);
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_OUTPUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/kyber_operand_streamer.sv
// Streams one operand from the byte RAM to the core: issues reads at base+idx,
// presents each byte one cycle later, and raises full_in once the operand is drained.
module kyber_operand_streamer
    import kyber_enc_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_restart,
    input  logic              i_legal,
    input  logic              i_readin_ok,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [IDX_W-1:0]  i_len,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_readin,
    output logic [7:0]        o_din,
    output logic [IDX_W-1:0]  o_in_index,
    output logic              o_full_in,
    output logic              o_full_set
);

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_pend_idx;
    logic             r_pend_valid;
    logic             r_full_in;

    logic [IDX_W-1:0] w_idx_eff;
    logic             w_issue;

    // A type change restarts the operand in the same cycle, so the new type's byte 0 can issue immediately.
    assign w_idx_eff  = i_restart ? '0 : r_idx;
    assign w_issue    = !i_clear && i_legal && i_readin_ok && (w_idx_eff < i_len);
    assign o_full_set = !i_clear && i_legal && !i_restart && !r_full_in &&
                        (r_idx == i_len) && !r_pend_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx        <= '0;
            r_pend_idx   <= '0;
            r_pend_valid <= 1'b0;
            r_full_in    <= 1'b0;
        end else if (i_clear) begin
            r_idx        <= '0;
            r_pend_idx   <= '0;
            r_pend_valid <= 1'b0;
            r_full_in    <= 1'b0;
        end else begin
            r_pend_valid <= w_issue;
            if (w_issue) begin
                r_pend_idx <= w_idx_eff;
                r_idx      <= w_idx_eff + 1'b1;
            end else begin
                r_idx      <= w_idx_eff;
            end
            if (i_restart) begin
                r_full_in <= 1'b0;
            end else if (o_full_set) begin
                r_full_in <= 1'b1;
            end
        end
    end

    assign o_mem_rd_en = w_issue;
    assign o_mem_addr  = w_issue ? (i_base + w_idx_eff[ADDR_W-1:0]) : '0;
    assign o_readin    = r_pend_valid;
    assign o_din       = r_pend_valid ? i_mem_rdata : 8'd0;
    assign o_in_index  = r_pend_valid ? r_pend_idx : '0;
    assign o_full_in   = r_full_in;

endmodule

// File: rtl/kyber_enc_feeder.sv
// Host-side driver for kyber_pke_enc: serves the core's operand requests from the
// byte RAM, then reads the ciphertext word pairs out into the ciphertext RAM.
module kyber_enc_feeder
    import kyber_enc_pkg::*;
#(
    parameter int K         = 3,
    parameter int ADDR_W    = 11,
    parameter int BASE_R    = 0,
    parameter int BASE_EKT  = 32,
    parameter int BASE_MSG  = 1184,
    parameter int BASE_SEED = 1216,
    parameter int C_PAIRS   = 272
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_ct_valid,
    output logic              o_err,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_ct_wr_en,
    output logic [8:0]        o_ct_wr_addr,
    output logic [31:0]       o_ct_wr_data,
    output logic              o_set,
    output logic              o_readin,
    output logic              o_readout,
    output logic              o_full_in,
    output logic [3:0]        o_data_type,
    output logic [7:0]        o_kyber_din,
    output logic [15:0]       o_kyber_in_index,
    input  logic [3:0]        i_input_type,
    input  logic              i_readin_ok,
    input  logic [15:0]       i_kyber_dout_1,
    input  logic [15:0]       i_kyber_dout_2,
    input  logic [15:0]       i_kyber_out_index,
    input  logic              i_done
);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_data_type;
    logic [3:0]        r_served;
    logic              r_err;
    logic [15:0]       r_cap_cnt;
    logic              r_cap_seen;
    logic [15:0]       r_last_idx;
    logic              r_ct_wr_en;
    logic [8:0]        r_ct_wr_addr;
    logic [31:0]       r_ct_wr_data;

    logic              w_start_ok;
    logic              w_in_serve;
    logic              w_legal;
    logic              w_restart;
    logic              w_full_set;
    logic [1:0]        w_type_bit;
    logic [ADDR_W-1:0] w_base;
    logic [IDX_W-1:0]  w_len;
    logic              w_cap_evt;
    logic              w_cap_ok;

    // The core's done flag carries no information the capture count does not already give.
    logic w_unused;
    assign w_unused = i_done;

    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_in_serve = (r_state == S_SERVE);
    assign w_legal    = isLegalType(i_input_type);
    assign w_restart  = w_in_serve && (i_input_type != r_data_type);
    assign w_type_bit = i_input_type[1:0] - 2'd1;

    always_comb begin
        w_base = '0;
        w_len  = '0;
        case (i_input_type)
            T_R:     begin w_base = ADDR_W'(BASE_R);    w_len = IDX_W'(LEN_R);      end
            T_EKT:   begin w_base = ADDR_W'(BASE_EKT);  w_len = IDX_W'(LEN_EKT(K)); end
            T_MSG:   begin w_base = ADDR_W'(BASE_MSG);  w_len = IDX_W'(LEN_MSG);    end
            T_SEED:  begin w_base = ADDR_W'(BASE_SEED); w_len = IDX_W'(LEN_SEED);   end
            default: begin w_base = '0;                 w_len = '0;                 end
        endcase
    end

    kyber_operand_streamer #(
        .ADDR_W(ADDR_W)
    ) u_streamer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (!w_in_serve),
        .i_restart   (w_restart),
        .i_legal     (w_legal),
        .i_readin_ok (i_readin_ok),
        .i_base      (w_base),
        .i_len       (w_len),
        .i_mem_rdata (i_mem_rdata),
        .o_mem_rd_en (o_mem_rd_en),
        .o_mem_addr  (o_mem_addr),
        .o_readin    (o_readin),
        .o_din       (o_kyber_din),
        .o_in_index  (o_kyber_in_index),
        .o_full_in   (o_full_in),
        .o_full_set  (w_full_set)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next_state = S_SERVE;
            S_SERVE:  if ((i_input_type == T_NONE) && (r_served == 4'hF)) w_next_state = S_OUTPUT;
            S_OUTPUT: if (r_cap_cnt == 16'(C_PAIRS)) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = 1'b0;
        o_set      = 1'b0;
        o_readout  = 1'b0;
        o_ct_valid = 1'b0;
        case (r_state)
            S_SERVE:  begin o_busy = 1'b1; o_set = 1'b1; end
            S_OUTPUT: begin o_busy = 1'b1; o_set = 1'b1; o_readout = 1'b1; end
            S_DONE:   o_ct_valid = 1'b1;
            default:  o_busy = 1'b0;
        endcase
    end

    // Pairs are captured on the first readout cycle and then on every change of the core's index.
    assign w_cap_evt = (r_state == S_OUTPUT) && (r_cap_cnt < 16'(C_PAIRS)) &&
                       (!r_cap_seen || (i_kyber_out_index != r_last_idx));
    assign w_cap_ok  = i_kyber_out_index < 16'(C_PAIRS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_type  <= '0;
            r_served     <= '0;
            r_err        <= 1'b0;
            r_cap_cnt    <= '0;
            r_cap_seen   <= 1'b0;
            r_last_idx   <= '0;
            r_ct_wr_en   <= 1'b0;
            r_ct_wr_addr <= '0;
            r_ct_wr_data <= '0;
        end else begin
            r_data_type <= w_in_serve ? i_input_type : T_NONE;
            r_ct_wr_en  <= w_cap_evt && w_cap_ok;
            if (w_start_ok) begin
                r_served  <= '0;
                r_err     <= 1'b0;
                r_cap_cnt <= '0;
            end else begin
                if (w_full_set) r_served[w_type_bit] <= 1'b1;
                if (w_in_serve && !w_legal && (i_input_type != T_NONE)) r_err <= 1'b1;
                if (w_cap_evt && !w_cap_ok) r_err <= 1'b1;
                if (w_cap_evt && w_cap_ok) r_cap_cnt <= r_cap_cnt + 1'b1;
            end
            if (r_state != S_OUTPUT) begin
                r_cap_seen <= 1'b0;
            end else if (w_cap_evt) begin
                r_cap_seen <= 1'b1;
                r_last_idx <= i_kyber_out_index;
            end
            if (w_cap_evt && w_cap_ok) begin
                r_ct_wr_addr <= i_kyber_out_index[8:0];
                r_ct_wr_data <= {i_kyber_dout_2, i_kyber_dout_1};
            end
        end
    end

    assign o_data_type  = r_data_type;
    assign o_err        = r_err;
    assign o_ct_wr_en   = r_ct_wr_en;
    assign o_ct_wr_addr = r_ct_wr_addr;
    assign o_ct_wr_data = r_ct_wr_data;

endmodule

// File: tb/tb_kyber_enc_feeder.sv
// Scoreboard bench for kyber_enc_feeder: a behavioural byte RAM and core model drive
// operand requests and ciphertext pairs, expected bytes/pairs are queued as they are requested.
module tb_kyber_enc_feeder;
    import kyber_enc_pkg::*;

    localparam int K         = 3;
    localparam int ADDR_W    = 11;
    localparam int BASE_R    = 0;
    localparam int BASE_EKT  = 32;
    localparam int BASE_MSG  = 1184;
    localparam int BASE_SEED = 1216;
    localparam int C_PAIRS   = 272;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              start = 1'b0;
    logic              busy, ctValid, err, memRdEn, ctWrEn, setOut, readin, readout, fullIn;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memRdata = 8'd0;
    logic [8:0]        ctWrAddr;
    logic [31:0]       ctWrData;
    logic [3:0]        dataType;
    logic [7:0]        kyberDin;
    logic [15:0]       kyberInIndex;
    logic [3:0]        inputType = 4'd0;
    logic              readinOk = 1'b0;
    logic [15:0]       dout1 = 16'd0;
    logic [15:0]       dout2 = 16'd0;
    logic [15:0]       outIndex = 16'd0;
    logic              coreDone = 1'b0;

    typedef struct packed {
        logic [15:0] idx;
        logic [7:0]  din;
        logic [3:0]  dtype;
    } byteExp_t;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } ctExp_t;

    byteExp_t byteQ[$];
    ctExp_t   ctQ[$];
    byteExp_t monByte;
    ctExp_t   monCt;

    int compareCount  = 0;
    int mismatchCount = 0;
    int readinCount   = 0;
    int ctWrCount     = 0;
    int ctValidCount  = 0;
    int cyc;

    logic [7:0] ram [0:2047];

    kyber_enc_feeder #(
        .K(K), .ADDR_W(ADDR_W), .BASE_R(BASE_R), .BASE_EKT(BASE_EKT),
        .BASE_MSG(BASE_MSG), .BASE_SEED(BASE_SEED), .C_PAIRS(C_PAIRS)
    ) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start),
        .o_busy(busy), .o_ct_valid(ctValid), .o_err(err),
        .o_mem_rd_en(memRdEn), .o_mem_addr(memAddr), .i_mem_rdata(memRdata),
        .o_ct_wr_en(ctWrEn), .o_ct_wr_addr(ctWrAddr), .o_ct_wr_data(ctWrData),
        .o_set(setOut), .o_readin(readin), .o_readout(readout), .o_full_in(fullIn),
        .o_data_type(dataType), .o_kyber_din(kyberDin), .o_kyber_in_index(kyberInIndex),
        .i_input_type(inputType), .i_readin_ok(readinOk),
        .i_kyber_dout_1(dout1), .i_kyber_dout_2(dout2),
        .i_kyber_out_index(outIndex), .i_done(coreDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ramByte(input int a);
        return 8'(a + (a >> 8) * 37);
    endfunction

    function automatic logic [15:0] pairLo(input int i);
        return 16'(i * 7 + 3);
    endfunction

    function automatic logic [15:0] pairHi(input int i);
        return 16'(16'hA000 ^ i);
    endfunction

    initial begin
        for (int a = 0; a < 2048; a++) ram[a] = ramByte(a);
    end

    always @(posedge clk) begin
        if (memRdEn) memRdata <= ram[memAddr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: every strobe the DUT produces is matched against the head of its queue.
    always @(negedge clk) begin
        if (rstN) begin
            if (readin) begin
                readinCount++;
                if (byteQ.size() == 0) begin
                    checkOutput("readinUnexpected", {63'd0, readin}, 64'd0);
                end else begin
                    monByte = byteQ.pop_front();
                    checkOutput("inIndex", kyberInIndex, monByte.idx);
                    checkOutput("din", kyberDin, monByte.din);
                    checkOutput("dataType", dataType, monByte.dtype);
                end
            end
            if (ctWrEn) begin
                ctWrCount++;
                if (ctQ.size() == 0) begin
                    checkOutput("ctWrUnexpected", {63'd0, ctWrEn}, 64'd0);
                end else begin
                    monCt = ctQ.pop_front();
                    checkOutput("ctWrAddr", ctWrAddr, monCt.addr);
                    checkOutput("ctWrData", ctWrData, monCt.data);
                end
            end
            if (ctValid) ctValidCount++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic startPulse();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        checkOutput("startBusy", busy, 1);
        checkOutput("startSet", setOut, 1);
    endtask

    // Request operand t from the DUT and queue every byte the core should receive.
    task automatic applyStimulus(input logic [3:0] t);
        int base;
        int len;
        tick();
        inputType = t;
        readinOk  = 1'b1;
        case (t)
            T_R:     begin base = BASE_R;    len = LEN_R;      end
            T_EKT:   begin base = BASE_EKT;  len = LEN_EKT(K); end
            T_MSG:   begin base = BASE_MSG;  len = LEN_MSG;    end
            T_SEED:  begin base = BASE_SEED; len = LEN_SEED;   end
            default: begin base = 0;         len = 0;          end
        endcase
        for (int i = 0; i < len; i++) byteQ.push_back({16'(i), ramByte(base + i), t});
    endtask

    task automatic serveOperand(input logic [3:0] t, input bit toggle, output int cycles);
        applyStimulus(t);
        cycles = 0;
        do begin
            tick();
            if (toggle) readinOk = ~readinOk;
            sample();
            cycles++;
        end while (!fullIn && cycles < 3000);
        readinOk = 1'b1;
        checkOutput("fullInRaised", fullIn, 1);
        checkOutput("byteQueueDrained", byteQ.size(), 0);
    endtask

    task automatic driveCtIndex(input int i);
        outIndex = 16'(i);
        dout1    = pairLo(i);
        dout2    = pairHi(i);
        if (i < C_PAIRS) ctQ.push_back({9'(i), pairHi(i), pairLo(i)});
    endtask

    task automatic runOutput(input bit injectBad, input bit pokeStart);
        int v0;
        int w0;
        int n;
        v0 = ctValidCount;
        w0 = ctWrCount;
        tick();
        driveCtIndex(0);
        inputType = T_NONE;
        n = 0;
        do begin
            sample();
            n++;
        end while (!readout && n < 10);
        checkOutput("readoutHigh", readout, 1);
        checkOutput("outputBusy", busy, 1);
        tick();
        for (int i = 1; i < C_PAIRS; i++) begin
            if (injectBad && i == 60) begin
                driveCtIndex(300);
                tick();
                tick();
            end
            driveCtIndex(i);
            if (pokeStart && i == 100) start = 1'b1;
            coreDone = (i == 150);
            tick();
            start = 1'b0;
            tick();
        end
        coreDone = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        sample();
        checkOutput("ctValidPulses", ctValidCount - v0, 1);
        checkOutput("ctWrPulses", ctWrCount - w0, C_PAIRS);
        checkOutput("ctQueueDrained", ctQ.size(), 0);
        checkOutput("doneBusy", busy, 0);
        checkOutput("doneReadout", readout, 0);
        checkOutput("doneSet", setOut, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] kyber_enc_feeder bench starting");
        for (int c = 0; c < 3; c++) tick();
        sample();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstCtValid", ctValid, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstMemRdEn", memRdEn, 0);
        checkOutput("rstSet", setOut, 0);
        checkOutput("rstReadout", readout, 0);
        checkOutput("rstDataType", dataType, 0);
        tick();
        rstN = 1'b1;

        // Abort a run with reset while R is at idx 17.
        startPulse();
        applyStimulus(T_R);
        for (int c = 0; c < 17; c++) tick();
        rstN = 1'b0;
        sample();
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortSet", setOut, 0);
        checkOutput("abortReadin", readin, 0);
        checkOutput("abortMemRdEn", memRdEn, 0);
        checkOutput("abortInIndex", kyberInIndex, 0);
        checkOutput("abortDataType", dataType, 0);
        checkOutput("abortCtValid", ctValid, 0);
        byteQ.delete();
        tick();
        inputType = T_NONE;
        tick();
        rstN = 1'b1;

        // Run 1: full service, out-of-range pair index, start poked during OUTPUT.
        startPulse();
        begin
            int r0;
            r0 = readinCount;
            serveOperand(T_R, 1'b0, cyc);
            checkOutput("fullLatencyR", cyc, 34);
            checkOutput("readinCountR", readinCount - r0, 32);
            r0 = readinCount;
            serveOperand(T_EKT, 1'b1, cyc);
            checkOutput("readinCountEkt", readinCount - r0, LEN_EKT(K));
        end
        serveOperand(T_MSG, 1'b0, cyc);
        serveOperand(T_SEED, 1'b0, cyc);
        runOutput(1'b1, 1'b1);
        checkOutput("badIndexErr", err, 1);

        // Run 2: illegal type, zero type with incomplete mask, then a clean run.
        startPulse();
        checkOutput("startClearsErr", err, 0);
        tick();
        inputType = 4'd7;
        readinOk  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            sample();
            checkOutput("illegalNoRead", memRdEn, 0);
            tick();
        end
        sample();
        checkOutput("illegalErr", err, 1);
        checkOutput("illegalBusy", busy, 1);
        tick();
        inputType = T_NONE;
        for (int c = 0; c < 3; c++) tick();
        sample();
        checkOutput("incompleteNoReadout", readout, 0);
        checkOutput("incompleteBusy", busy, 1);
        serveOperand(T_R, 1'b0, cyc);
        serveOperand(T_EKT, 1'b0, cyc);
        serveOperand(T_MSG, 1'b0, cyc);
        serveOperand(T_SEED, 1'b1, cyc);
        runOutput(1'b0, 1'b0);
        checkOutput("errSticky", err, 1);

        startPulse();
        checkOutput("restartClearsErr", err, 0);
        checkOutput("restartReadout", readout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
